// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer.
// The action classifier turns the current state, slot and input qualifiers
// into one decision. Every register in the top level then keys off that
// single decision.
package tdm_demux4_pkg;

    // Frame alignment state: hunting for sync, or tracking slots.
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Slot numbers, matching the far-end mux select pair {s1,s0}.
    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    localparam int NUM_SLOTS = 4;

    // What a given cycle does with the incoming word.
    typedef enum logic [2:0] {
        ACT_IDLE,      // no valid word this cycle
        ACT_DROP,      // hunting and the word carries no sync
        ACT_START,     // hunting and sync found: word becomes slot 0
        ACT_STORE,     // locked, word lands in staging[slot]
        ACT_COMPLETE,  // locked, slot-3 word closes the frame
        ACT_RESYNC,    // locked, sync at a non-zero slot: restart the frame
        ACT_LOST       // locked, slot 0 arrived without sync: go back to hunting
    } action_t;

    // Decide what to do with this cycle's word.
    // Inside LOCKED, a sync at slot 0 is an ordinary frame start, so it falls
    // through to the store path like any other slot-0 word.
    function automatic action_t classify(
        input state_t     st,
        input logic       valid,
        input logic       sync,
        input logic [1:0] cur_slot
    );
        action_t act;
        if (!valid) begin
            act = ACT_IDLE;
        end else if (st == ST_HUNT) begin
            act = sync ? ACT_START : ACT_DROP;
        end else if (sync && (cur_slot != SLOT_A)) begin
            act = ACT_RESYNC;
        end else if (!sync && (cur_slot == SLOT_A)) begin
            act = ACT_LOST;
        end else if (cur_slot == SLOT_D) begin
            act = ACT_COMPLETE;
        end else begin
            act = ACT_STORE;
        end
        return act;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Two-bit slot counter that mirrors the far-end mux select pair.
// Control priority: clear (back to hunting) wins over load-to-1 (a sync word
// was just taken as slot 0), which wins over a plain increment.
// The wrap flag marks an increment out of the last slot, i.e. a frame that
// completes on this edge.
module tdm_slot_ctr
    import tdm_demux4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load_one,
    input  logic       clear,
    output logic [1:0] slot,
    output logic       wrap
);

    // Slot register: async clear on reset, then clear/load/increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= SLOT_A;
        end else if (clear) begin
            slot <= SLOT_A;
        end else if (load_one) begin
            slot <= SLOT_B;
        end else if (inc) begin
            slot <= slot + 2'd1;
        end
    end

    assign wrap = inc && (slot == SLOT_D);

endmodule

// File: rtl/tdm_demux4.sv
// Receiving end of a 4:1 TDM link.
// The block hunts for frame sync, then steers each valid word into a staging
// register chosen by the slot counter. A full frame is published to ch_a..ch_d
// with a one-cycle frame_valid strobe.
// The slot-3 word goes straight to ch_d, so a frame needs only three staging
// registers.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sync,
    output logic [WIDTH-1:0] ch_a,
    output logic [WIDTH-1:0] ch_b,
    output logic [WIDTH-1:0] ch_c,
    output logic [WIDTH-1:0] ch_d,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    state_t           state;
    action_t          act;
    logic [1:0]       slot_q;
    logic             ctr_inc;
    logic             ctr_load;
    logic             ctr_clear;
    logic             frame_done;
    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;
    logic [WIDTH-1:0] stage_c;

    assign act = classify(state, in_valid, in_sync, slot_q);

    // Translate the cycle's action into slot-counter controls.
    always_comb begin
        ctr_inc   = 1'b0;
        ctr_load  = 1'b0;
        ctr_clear = 1'b0;
        case (act)
            ACT_STORE,
            ACT_COMPLETE: ctr_inc   = 1'b1;
            ACT_START,
            ACT_RESYNC:   ctr_load  = 1'b1;
            ACT_LOST:     ctr_clear = 1'b1;
            default:      ;
        endcase
    end

    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (ctr_inc),
        .load_one (ctr_load),
        .clear    (ctr_clear),
        .slot     (slot_q),
        .wrap     (frame_done)
    );

    // Alignment state: lock on the first sync, fall back when a sync goes missing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            case (act)
                ACT_START: state <= ST_LOCKED;
                ACT_LOST:  state <= ST_HUNT;
                default:   state <= state;
            endcase
        end
    end

    // Staging registers for slots 0..2. A resync overwrites slot 0, which abandons the old partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_a <= '0;
            stage_b <= '0;
            stage_c <= '0;
        end else begin
            case (act)
                ACT_START,
                ACT_RESYNC: stage_a <= in_data;
                ACT_STORE: begin
                    case (slot_q)
                        SLOT_A:  stage_a <= in_data;
                        SLOT_B:  stage_b <= in_data;
                        SLOT_C:  stage_c <= in_data;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Publish a finished frame and strobe frame_valid for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_a        <= '0;
            ch_b        <= '0;
            ch_c        <= '0;
            ch_d        <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                ch_a <= stage_a;
                ch_b <= stage_b;
                ch_c <= stage_c;
                ch_d <= in_data;
            end
        end
    end

    // Sticky misalignment flag. Only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if (act == ACT_RESYNC) begin
            sync_err <= 1'b1;
        end
    end

    assign slot   = slot_q;
    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4.
// The reference model holds the partial frame as a queue of words: the queue
// length is the expected slot, and four queued words make a published frame.
module tb_tdm_demux4;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_sync;
    logic [W-1:0] in_data;
    logic [W-1:0] ch_a, ch_b, ch_c, ch_d;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_ch[4];
    bit           m_locked;
    bit           m_fv;
    bit           m_err;

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_sync     (in_sync),
        .ch_a        (ch_a),
        .ch_b        (ch_b),
        .ch_c        (ch_c),
        .ch_d        (ch_d),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    function automatic logic [1:0] m_slot();
        return 2'(m_q.size());
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
        m_locked = 0;
        m_fv     = 0;
        m_err    = 0;
    endtask

    // Apply one valid word to the model.
    task automatic model_word(input bit sync, input logic [W-1:0] d);
        if (!m_locked) begin
            if (sync) begin
                m_q.delete();
                m_q.push_back(d);
                m_locked = 1;
            end
        end else if (sync && m_q.size() != 0) begin
            m_err = 1;
            m_q.delete();
            m_q.push_back(d);
        end else if (!sync && m_q.size() == 0) begin
            m_locked = 0;
        end else begin
            m_q.push_back(d);
            if (m_q.size() == 4) begin
                for (int i = 0; i < 4; i++) m_ch[i] = m_q[i];
                m_fv = 1;
                m_q.delete();
            end
        end
    endtask

    // One clock of stimulus. Drive on the falling edge, update the model at the
    // rising edge, and return 1ns later so the caller samples the settled outputs.
    task automatic step(input bit v, input bit s, input logic [W-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        m_fv = 0;
        if (v) model_word(s, d);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;
        model_reset();
        #2;
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ch got %h want 0", {ch_a, ch_b, ch_c, ch_d});
        end
        checks++;
        if ({frame_valid, slot, locked, sync_err} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_status got %b want 00000", {frame_valid, slot, locked, sync_err});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({locked, slot} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_release locked/slot got %b want 000", {locked, slot});
        end
    endtask

    task automatic test_basic();
        step(1, 1, 8'h00);
        step(1, 0, 8'h01);
        step(1, 0, 8'h01);
        step(1, 0, 8'h00);
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== {8'h00, 8'h01, 8'h01, 8'h00}) begin
            errors++;
            $display("[TB] FAIL basic_ch got %h want 00010100", {ch_a, ch_b, ch_c, ch_d});
        end
        checks++;
        if (frame_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_fv_high got %b want 1", frame_valid);
        end
        step(0, 0, 8'h00);
        checks++;
        if ({frame_valid, locked, slot} !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL basic_after fv/locked/slot got %b want 0100", {frame_valid, locked, slot});
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[8];
        int fv_cyc[$];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) begin
            step(1, (i == 0 || i == 4), words[i]);
            if (frame_valid === 1'b1) fv_cyc.push_back(i);
            checks++;
            if ({frame_valid, slot, locked, sync_err} !== {m_fv, m_slot(), m_locked, m_err}) begin
                errors++;
                $display("[TB] FAIL b2b_status[%0d] got %b want %b", i,
                         {frame_valid, slot, locked, sync_err}, {m_fv, m_slot(), m_locked, m_err});
            end
        end
        checks++;
        if (fv_cyc.size() != 2 || (fv_cyc[1] - fv_cyc[0]) != 4) begin
            errors++;
            $display("[TB] FAIL b2b_pulses got %0d pulses want 2 spaced by 4", fv_cyc.size());
        end
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h55667788) begin
            errors++;
            $display("[TB] FAIL b2b_ch got %h want 55667788", {ch_a, ch_b, ch_c, ch_d});
        end
    endtask

    task automatic test_hunt();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'(8'hA0 + i));
            checks++;
            if ({frame_valid, slot, locked} !== 4'b0000 || {ch_a, ch_b, ch_c, ch_d} !== '0) begin
                errors++;
                $display("[TB] FAIL hunt_drop[%0d] got fv/slot/locked %b ch %h want 0000 ch 0", i,
                         {frame_valid, slot, locked}, {ch_a, ch_b, ch_c, ch_d});
            end
        end
        step(1, 1, 8'hC1);
        step(1, 0, 8'hC2);
        step(1, 0, 8'hC3);
        step(1, 0, 8'hC4);
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'hC1C2C3C4 || frame_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hunt_frame got ch %h fv %b want C1C2C3C4 fv 1",
                     {ch_a, ch_b, ch_c, ch_d}, frame_valid);
        end
    endtask

    task automatic test_misalign();
        step(1, 1, 8'hD0);
        step(1, 0, 8'hD1);
        step(1, 1, 8'hE0);
        checks++;
        if ({sync_err, frame_valid, slot} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL misalign_flag err/fv/slot got %b want 1001", {sync_err, frame_valid, slot});
        end
        step(1, 0, 8'hE1);
        step(1, 0, 8'hE2);
        checks++;
        if (frame_valid !== 1'b0 || {ch_a, ch_b, ch_c, ch_d} !== 32'hC1C2C3C4) begin
            errors++;
            $display("[TB] FAIL misalign_hold got ch %h fv %b want C1C2C3C4 fv 0",
                     {ch_a, ch_b, ch_c, ch_d}, frame_valid);
        end
        step(1, 0, 8'hE3);
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'hE0E1E2E3 || frame_valid !== 1'b1 || sync_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_frame got ch %h fv %b err %b want E0E1E2E3 1 1",
                     {ch_a, ch_b, ch_c, ch_d}, frame_valid, sync_err);
        end
        step(0, 0, 8'h00);
        checks++;
        if (sync_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_sticky got %b want 1", sync_err);
        end
    endtask

    task automatic test_gaps();
        pulse_reset();
        step(1, 1, 8'h31);
        step(1, 0, 8'h32);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'hFF);
            checks++;
            if ({frame_valid, slot, locked} !== 4'b0101) begin
                errors++;
                $display("[TB] FAIL gap_wait[%0d] fv/slot/locked got %b want 0101", i, {frame_valid, slot, locked});
            end
        end
        step(1, 0, 8'h33);
        step(1, 0, 8'h34);
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h31323334 || frame_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gap_frame got ch %h fv %b want 31323334 fv 1", {ch_a, ch_b, ch_c, ch_d}, frame_valid);
        end
    endtask

    task automatic test_mid_reset();
        step(1, 1, 8'h41);
        step(1, 0, 8'h42);
        step(1, 0, 8'h43);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== '0 || {frame_valid, slot, locked, sync_err} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async got ch %h status %b want all 0",
                     {ch_a, ch_b, ch_c, ch_d}, {frame_valid, slot, locked, sync_err});
        end
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 8'h44);
        checks++;
        if (frame_valid !== 1'b0 || {ch_a, ch_b, ch_c, ch_d} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_nofv got ch %h fv %b want 0 0", {ch_a, ch_b, ch_c, ch_d}, frame_valid);
        end
        step(1, 1, 8'h51);
        step(1, 0, 8'h52);
        step(1, 0, 8'h53);
        step(1, 0, 8'h54);
        checks++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h51525354 || frame_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_frame got ch %h fv %b want 51525354 1", {ch_a, ch_b, ch_c, ch_d}, frame_valid);
        end
    endtask

    task automatic test_random();
        bit v, s;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 99) < 75);
            if (m_q.size() == 0) s = ($urandom_range(0, 99) < 80);
            else                 s = ($urandom_range(0, 99) < 8);
            step(v, s, W'($urandom));
            checks++;
            if ({ch_a, ch_b, ch_c, ch_d} !== {m_ch[0], m_ch[1], m_ch[2], m_ch[3]}) begin
                errors++;
                $display("[TB] FAIL rand_ch[%0d] got %h want %h", i,
                         {ch_a, ch_b, ch_c, ch_d}, {m_ch[0], m_ch[1], m_ch[2], m_ch[3]});
            end
            checks++;
            if ({frame_valid, slot, locked, sync_err} !== {m_fv, m_slot(), m_locked, m_err}) begin
                errors++;
                $display("[TB] FAIL rand_status[%0d] got %b want %b", i,
                         {frame_valid, slot, locked, sync_err}, {m_fv, m_slot(), m_locked, m_err});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hunt();
        test_misalign();
        test_gaps();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
